// File: rtl/conv_host_if.sv
// conv_host_if: job request, engine nibble/result stream and result-read signals of conv_host
`timescale 1ns/1ps
interface conv_host_if;
    logic        start;
    logic [31:0] f_vec;
    logic [31:0] g_vec;
    logic        busy;
    logic        in_en;
    logic [3:0]  Din;
    logic        out_valid;
    logic [7:0]  Dout;
    logic [3:0]  res_addr;
    logic [7:0]  res_data;
    logic [11:0] res_sum;
    logic        done;
    logic        err;
    modport master (
        input  start, f_vec, g_vec, busy, out_valid, Dout, res_addr,
        output in_en, Din, res_data, res_sum, done, err
    );
    modport slave (
        output start, f_vec, g_vec, busy, out_valid, Dout, res_addr,
        input  in_en, Din, res_data, res_sum, done, err
    );
endinterface

// File: rtl/conv_host.sv
// conv_host: streams two latched 8-nibble operands to a convolution engine and
// collects its 15 result bytes into a readable buffer with a running sum.
`timescale 1ns/1ps
module conv_host #(
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_host_if.master    bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, WAIT_RDY, SEND, COLLECT, DONE, FAIL} state_t;
    state_t         state_q, state_d;
    logic [63:0]    ops_q, ops_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           busy_q;
    logic           in_en_q, in_en_d;
    logic [3:0]     din_q, din_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [11:0]    sum_q, sum_d;
    logic [7:0]     rbuf_q [15];
    logic [7:0]     rbuf_d [15];

    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        in_en_d = 1'b0;
        din_d   = 4'd0;
        done_d  = done_q;
        err_d   = err_q;
        sum_d   = sum_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (bus.start) begin
                    state_d = WAIT_RDY;
                    ops_d   = {bus.g_vec, bus.f_vec};
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    sum_d   = 12'd0;
                    idx_d   = 4'd0;
                    rbuf_d  = '{default: '0};
                end
            end
            WAIT_RDY: begin
                if (!busy_q) begin
                    state_d = SEND;
                    in_en_d = 1'b1;
                    din_d   = ops_q[3:0];
                    cnt_d   = 4'd0;
                end
            end
            SEND: begin
                // cnt_q is the index of the nibble currently on Din
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = COLLECT;
                    tmo_d   = '0;
                end else begin
                    in_en_d = 1'b1;
                    din_d   = ops_q[{cnt_d, 2'b00} +: 4];
                end
            end
            COLLECT: begin
                if (bus.out_valid) begin
                    rbuf_d[idx_q] = bus.Dout;
                    sum_d         = sum_q + 12'(bus.Dout);
                    idx_d         = idx_q + 4'd1;
                    if (idx_q == 4'd14) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (idx_q == 4'd0) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_d = FAIL;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ops_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b1;
            in_en_q <= 1'b0;
            din_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= '0;
            rbuf_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            busy_q  <= bus.busy;
            in_en_q <= in_en_d;
            din_q   <= din_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assign bus.in_en    = in_en_q;
    assign bus.Din      = din_q;
    assign bus.res_data = (bus.res_addr == 4'hF) ? 8'd0 : rbuf_q[bus.res_addr];
    assign bus.res_sum  = sum_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_conv_host.sv
// tb_conv_host: randomized jobs against a convolution reference model, with a
// nibble scoreboard on the engine stream and a result monitor on done/err.
`timescale 1ns/1ps
module tb_conv_host;
    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic         fail;
        logic [119:0] res;
        logic [11:0]  sum;
    } job_t;

    logic clk;
    logic rst_n;
    conv_host_if bus();

    conv_host #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] exp_nib[$];
    logic [3:0] eng_rx[$];
    job_t       exp_jobs[$];
    bit eng_silent = 0;
    bit eng_extra  = 0;
    bit recheck    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Full linear convolution of the two nibble vectors, truncated to a byte per term
    function automatic job_t model(input logic [31:0] f, input logic [31:0] g, input bit fail);
        job_t j;
        int acc;
        j.fail = fail;
        j.res  = '0;
        j.sum  = '0;
        if (!fail) begin
            for (int n = 0; n < 15; n++) begin
                acc = 0;
                for (int i = 0; i < 8; i++)
                    if (n - i >= 0 && n - i < 8)
                        acc += int'((f >> (4 * i)) & 32'hF) * int'((g >> (4 * (n - i))) & 32'hF);
                j.res[8 * n +: 8] = 8'(acc & 255);
                j.sum = j.sum + 12'(acc & 255);
            end
        end
        return j;
    endfunction

    // Stream monitor: every presented nibble is scored, and bursts must be 16 long
    int  run_len = 0;
    bit  prev_en = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            prev_en = 0;
        end else begin
            if (bus.in_en) begin
                run_len++;
                if (exp_nib.size() == 0) check("din_unexpected", 32'(bus.in_en), 0);
                else check("din", 32'(bus.Din), 32'(exp_nib.pop_front()));
                eng_rx.push_back(bus.Din);
            end else begin
                if (prev_en) begin
                    check("burst_len", run_len, 16);
                    run_len = 0;
                end
                check("din_idle", 32'(bus.Din), 0);
            end
            prev_en = bus.in_en;
        end
    end

    // Engine model: convolves what it actually received and returns it with random gaps
    initial begin : engine
        logic [7:0] r [15];
        int acc;
        bus.out_valid = 1'b0;
        bus.Dout      = 8'd0;
        forever begin
            @(negedge clk);
            if (eng_rx.size() >= 16) begin
                for (int n = 0; n < 15; n++) begin
                    acc = 0;
                    for (int i = 0; i < 8; i++)
                        if (n - i >= 0 && n - i < 8) acc += int'(eng_rx[i]) * int'(eng_rx[8 + n - i]);
                    r[n] = 8'(acc & 255);
                end
                eng_rx.delete();
                if (!eng_silent) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    for (int n = 0; n < 15; n++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        bus.out_valid = 1'b1;
                        bus.Dout      = r[n];
                        @(negedge clk);
                        bus.out_valid = 1'b0;
                        bus.Dout      = 8'd0;
                    end
                    if (eng_extra) begin
                        for (int n = 0; n < 16; n++) begin
                            @(negedge clk);
                            bus.out_valid = 1'b1;
                            bus.Dout      = 8'($urandom);
                            @(negedge clk);
                            bus.out_valid = 1'b0;
                            bus.Dout      = 8'd0;
                        end
                    end
                end
            end
        end
    end

    task automatic verify(input job_t j, input string tag);
        for (int a = 0; a < 16; a++) begin
            bus.res_addr = 4'(a);
            #0.25;
            check({tag, "_res_data"}, 32'(bus.res_data), (a == 15) ? 32'd0 : 32'(j.res[8 * a +: 8]));
        end
        check({tag, "_res_sum"}, 32'(bus.res_sum), 32'(j.sum));
    endtask

    // Result monitor: scores each job end against the oldest expected job
    initial begin : results
        job_t j, last;
        bit pd, pe, pen;
        int since;
        last = '0;
        pd = 0; pe = 0; pen = 0; since = 0;
        bus.res_addr = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pd = 0; pe = 0; pen = 0;
            end else begin
                if (pen && !bus.in_en) since = 0;
                else since++;
                pen = bus.in_en;
                if ((bus.done && !pd) || (bus.err && !pe)) begin
                    if (exp_jobs.size() == 0) check("unexpected_end", 32'(bus.done | bus.err), 0);
                    else begin
                        j = exp_jobs.pop_front();
                        last = j;
                        check("err_flag", 32'(bus.err), 32'(j.fail));
                        check("done_flag", 32'(bus.done), 32'(!j.fail));
                        if (j.fail) begin
                            check("timeout_cycles", since, TIMEOUT);
                            check("fail_res_sum", 32'(bus.res_sum), 0);
                        end else verify(j, "job");
                    end
                end else if (recheck) begin
                    verify(last, "hold");
                    check("hold_done", 32'(bus.done), 1);
                    recheck = 0;
                end
                pd = bus.done;
                pe = bus.err;
            end
        end
    end

    task automatic push_nibbles(input logic [31:0] f, input logic [31:0] g);
        for (int k = 0; k < 8; k++) exp_nib.push_back(4'((f >> (4 * k)) & 32'hF));
        for (int k = 0; k < 8; k++) exp_nib.push_back(4'((g >> (4 * k)) & 32'hF));
    endtask

    task automatic pulse_start(input logic [31:0] f, input logic [31:0] g);
        bus.f_vec = f;
        bus.g_vec = g;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.f_vec = $urandom;
        bus.g_vec = $urandom;
    endtask

    task automatic run_job(input logic [31:0] f, input logic [31:0] g, input int busy_cyc,
                           input bit silent, input bit poke);
        int t;
        push_nibbles(f, g);
        exp_jobs.push_back(model(f, g, silent));
        eng_silent = silent;
        eng_extra  = poke;
        bus.busy   = (busy_cyc > 0);
        pulse_start(f, g);
        if (busy_cyc > 0) begin
            repeat (busy_cyc) begin
                check("busy_hold_in_en", 32'(bus.in_en), 0);
                @(negedge clk);
            end
            bus.busy = 1'b0;
            @(negedge clk);
            check("rdy_lat_0", 32'(bus.in_en), 0);
            @(negedge clk);
            check("rdy_lat_1", 32'(bus.in_en), 1);
        end
        if (poke) begin
            t = 0;
            while (!bus.in_en && t < 100) begin @(negedge clk); t++; end
            while (bus.in_en && t < 100) begin @(negedge clk); t++; end
            check("poke_in_collect", 32'(bus.in_en | bus.done), 0);
            bus.busy = 1'b1;
            pulse_start($urandom, $urandom);
            bus.busy = 1'b0;
        end
        t = 0;
        while (!(bus.done || bus.err) && t < 3000) begin @(negedge clk); t++; end
        check("job_end", 32'(bus.done | bus.err), 1);
        @(negedge clk);
        if (poke) begin
            repeat (40) @(negedge clk);
            recheck = 1;
            t = 0;
            while (recheck && t < 10) begin @(negedge clk); t++; end
            check("recheck_served", 32'(recheck), 0);
        end
    endtask

    initial begin : main
        int t;
        logic [31:0] f, g;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.busy  = 1'b0;
        bus.f_vec = '0;
        bus.g_vec = '0;
        #1;
        check("rst_in_en", 32'(bus.in_en), 0);
        check("rst_din", 32'(bus.Din), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_res_sum", 32'(bus.res_sum), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(32'h11111111, 32'h11111111, 0, 0, 0);
        check("ones_sum", 32'(bus.res_sum), 64);
        run_job(32'h0000000F, 32'h0000000F, 0, 0, 0);
        check("f_sum", 32'(bus.res_sum), 225);
        run_job($urandom, $urandom, 10, 0, 0);
        run_job($urandom, $urandom, 0, 1, 0);
        check("timeout_err", 32'(bus.err), 1);
        check("timeout_done", 32'(bus.done), 0);
        run_job($urandom, $urandom, 0, 0, 0);
        check("restart_err", 32'(bus.err), 0);

        // Abort in the 8th SEND cycle, then confirm a clean full job afterwards
        f = $urandom;
        g = $urandom;
        push_nibbles(f, g);
        eng_silent = 0;
        eng_extra  = 0;
        pulse_start(f, g);
        t = 0;
        while (!bus.in_en && t < 20) begin @(negedge clk); t++; end
        check("abort_send_seen", 32'(bus.in_en), 1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_en", 32'(bus.in_en), 0);
        check("abort_din", 32'(bus.Din), 0);
        exp_nib.delete();
        eng_rx.delete();
        @(negedge clk);
        check("abort_res_sum", 32'(bus.res_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_resume", 32'(bus.in_en), 0);
        run_job($urandom, $urandom, 0, 0, 0);

        run_job($urandom, $urandom, 0, 0, 1);
        for (int i = 0; i < 5; i++) run_job($urandom, $urandom, $urandom_range(0, 3), 0, 0);
        check("jobs_drained", exp_jobs.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/conv_host.md
CONV_HOST -- requirements
Module: conv_host

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles from last sent nibble to first out_valid before error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to run one convolution job.
REQ-005 f_vec  input  32  operand f; f[k] = f_vec[4k+3:4k], k=0..7.
REQ-006 g_vec  input  32  operand g; g[k] = g_vec[4k+3:4k], k=0..7.
REQ-007 busy  input  1  engine not-ready flag (engine side of stream link).
REQ-008 in_en  output  1  nibble-valid strobe to engine.
REQ-009 Din  output  4  nibble to engine.
REQ-010 out_valid  input  1  engine result-valid strobe.
REQ-011 Dout  input  8  engine result byte.
REQ-012 res_addr  input  4  result read index, 0..14.
REQ-013 res_data  output  8  combinational read of result buffer at res_addr; 0 for res_addr=15.
REQ-014 res_sum  output  12  sum of the 15 captured bytes.
REQ-015 done  output  1  high while job completed and results valid.
REQ-016 err  output  1  high while last job ended in timeout.

Function
REQ-017 States SHALL be IDLE, WAIT_RDY, SEND, COLLECT, DONE, FAIL.
REQ-018 IDLE/DONE/FAIL + start=1: latch f_vec and g_vec, clear done, err, res_sum, capture index, go to WAIT_RDY next cycle; start ignored in WAIT_RDY, SEND, COLLECT.
REQ-019 WAIT_RDY: in_en=0; on registered-input busy=0 go to SEND next cycle; wait indefinitely while busy=1.
REQ-020 SEND: in_en=1 for exactly 16 consecutive cycles, no gaps, Din = f[0..7] then g[0..7] one per cycle; busy ignored during SEND.
REQ-021 After 16th nibble in_en=0, Din=0, go to COLLECT with timeout counter cleared.
REQ-022 Din SHALL be 0 whenever in_en=0.
REQ-023 COLLECT: each cycle with out_valid=1 store Dout into buffer[idx], add Dout (zero-extended) to res_sum, idx+1.
REQ-024 COLLECT: after 15th capture, go to DONE next cycle; done=1 from that cycle; out_valid pulses outside COLLECT SHALL be ignored.
REQ-025 Timeout counter increments each COLLECT cycle while idx=0 and out_valid=0; on reaching TIMEOUT go to FAIL, err=1, done=0.
REQ-026 Once idx>0, timeout disabled; gaps in out_valid tolerated.
REQ-027 Buffer and res_sum hold values until next accepted start; FAIL keeps partial contents.
REQ-028 res_sum width 12 bits; max 15*255=3825, no overflow.
REQ-029 Operand latch SHALL make f_vec/g_vec changes after start have no effect on the current job.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, in_en=0, Din=0, done=0, err=0, res_sum=0, buffer all 0, counters 0, regardless of current state.
REQ-031 Reset asserted mid-SEND or mid-COLLECT SHALL abort the job; no partial stream resumes after release.
REQ-032 First accepted start after reset release SHALL behave exactly as REQ-018.

Verification
REQ-033 f_vec=g_vec=32'h11111111, engine model -> Din sequence sixteen 1s; results 1,2,3,4,5,6,7,8,7,6,5,4,3,2,1; res_sum=64; done=1.
REQ-034 f_vec=32'h0000000F, g_vec=32'h0000000F -> res_data[0]=225, all others 0, res_sum=225.
REQ-035 busy held 1 for 10 cycles after start -> in_en stays 0 throughout; first in_en=1 one cycle after busy seen 0; 16-cycle burst unbroken.
REQ-036 Engine never asserts out_valid, TIMEOUT=255 -> err=1 exactly 255 COLLECT cycles after burst end; done=0; start then restarts cleanly.
REQ-037 reset=0 at 8th SEND cycle -> in_en=0 and Din=0 immediately; after release, new start yields correct full job.
REQ-038 start pulsed during COLLECT and 16 extra out_valid pulses after DONE -> ignored; buffer and res_sum unchanged.
